memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/y86_pkg.sv | 27 ++
 rtl/dmem.sv | 39 +++
 rtl/memory_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage: instruction codes, status codes
// and the default data-memory size.
package y86_pkg;

    localparam int MEM_BYTES_DEFAULT = 1024;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

endpackage

// File: rtl/dmem.sv
// Byte-addressed data memory: one 8-byte little-endian combinational read port,
// one 8-byte write port committed on the clock edge, synchronous clear on reset.
module dmem
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);

    logic [7:0] mem_q [MEM_BYTES];

    // Bytes past the end read as zero; the caller masks out-of-range reads anyway.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < 8; i++) begin
            if (({1'b0, addr_i} + (AW+1)'(i)) < (AW+1)'(MEM_BYTES)) begin
                rdata_o[8*i +: 8] = mem_q[addr_i + AW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else if (we_i) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[addr_i + AW'(i)] <= wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: address/data selection, range check, status priority and
// the sticky status register. Define MEM_STATS_EN to add load/store counters.
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic [2:0]  stat
`ifdef MEM_STATS_EN
    ,
    output logic [31:0] load_count,
    output logic [31:0] store_count
`endif
);

    localparam int AW = $clog2(MEM_BYTES);

    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] rdata;
    logic        mem_we;
    stat_e       cur_stat;
    stat_e       stat_q;
    stat_e       stat_d;

    assign mem_rd    = (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
    assign mem_wr    = (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
    assign mem_addr  = ((icode == I_POPQ) || (icode == I_RET)) ? valA : valE;
    assign mem_wdata = (icode == I_CALL) ? valP : valA;

    // Full 64-bit compare so wrapped addresses near 2^64 are rejected too.
    assign dmem_error = (mem_rd || mem_wr) && (mem_addr > 64'(MEM_BYTES - 8));

    always_comb begin
        cur_stat = STAT_AOK;
        if (imem_error)        cur_stat = STAT_ADR;
        else if (!instr_valid) cur_stat = STAT_INS;
        else if (dmem_error)   cur_stat = STAT_ADR;
        else if (icode == I_HALT) cur_stat = STAT_HLT;
    end

    always_ff @(posedge clk) begin
        if (reset) stat_q <= STAT_AOK;
        else       stat_q <= stat_d;
    end

    always_comb begin
        stat_d = stat_q;
        if (stat_q == STAT_AOK && cur_stat != STAT_AOK) stat_d = cur_stat;
    end

    assign stat   = (stat_q == STAT_AOK) ? cur_stat : stat_q;
    assign mem_we = mem_wr && (cur_stat == STAT_AOK) && (stat_q == STAT_AOK);
    assign valM   = (mem_rd && !dmem_error) ? rdata : 64'd0;

    dmem #(.MEM_BYTES(MEM_BYTES)) u_dmem (
        .clk     (clk),
        .reset   (reset),
        .addr_i  (mem_addr[AW-1:0]),
        .we_i    (mem_we),
        .wdata_i (mem_wdata),
        .rdata_o (rdata)
    );

`ifdef MEM_STATS_EN
    logic [31:0] load_q;
    logic [31:0] store_q;
    logic        rd_commit;

    assign rd_commit = mem_rd && (cur_stat == STAT_AOK) && (stat_q == STAT_AOK);

    always_ff @(posedge clk) begin
        if (reset) begin
            load_q  <= '0;
            store_q <= '0;
        end else begin
            if (rd_commit && load_q != 32'hFFFF_FFFF)  load_q  <= load_q + 32'd1;
            if (mem_we && store_q != 32'hFFFF_FFFF)    store_q <= store_q + 32'd1;
        end
    end

    assign load_count  = load_q;
    assign store_count = store_q;
`endif

endmodule
